// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the byte FIFO read port and the UART transmitter.
// master = transmitter side (drives rd_en and the serial outputs), slave = FIFO/pin side.
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       empty;
  logic [7:0] dt_out;
  logic       rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tx_en, empty, dt_out,
    output rd_en, tx, busy, frame_done
  );

  modport slave (
    output tx_en, empty, dt_out,
    input  rd_en, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame, sends start, 8 data bits LSB first, stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_uart_tx_if.master        bus
);

  localparam int unsigned        CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_end;
  logic timed;

  assign bit_end = (baud_q == BAUD_LAST);
  assign timed   = (state_q != S_IDLE) && (state_q != S_FETCH) && (state_q != S_WAIT);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    baud_d       = '0;
    bit_d        = bit_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    rd_en_d      = 1'b0;
    frame_done_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    if (timed) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.tx_en && !bus.empty) begin
          state_d = S_FETCH;
          rd_en_d = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // The FIFO sampled rd_en on the previous edge, so dt_out is valid now.
        shift_d  = bus.dt_out;
        tx_d     = 1'b0;
        state_d  = S_START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^bus.dt_out;
`endif
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      tx_q         <= 1'b1;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the 8-bit synchronous FIFO. It drains bytes from the FIFO read port (`rd_en` / `empty` / `dt_out`) and serialises each byte as an asynchronous UART frame on `tx`: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It sits between the byte FIFO and the chip's serial pin, and pops exactly one FIFO entry per transmitted frame.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_en`  input  1  permits fetching a new byte; sampled only in IDLE.
- `empty`  input  1  FIFO empty flag.
- `dt_out`  input  8  FIFO read data; valid one edge after `rd_en` is sampled high.
- `rd_en`  output  1  FIFO read strobe; registered, one-cycle pulse.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high whenever state is not IDLE.
- `frame_done`  output  1  one-cycle pulse at the end of the stop bit.

## Operation
- Reset values: `tx`=1, `rd_en`=0, `busy`=0, `frame_done`=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States are IDLE, FETCH, WAIT, START, DATA, PARITY (only when parity is compiled in), and STOP.
- IDLE: if `tx_en`=1 and `empty`=0, the block goes to FETCH and sets `rd_en`=1. Otherwise it stays in IDLE.
- FETCH: for one cycle the block clears `rd_en` and goes to WAIT. The FIFO samples the read on this edge.
- WAIT: for one cycle. The block loads `dt_out` into the 8-bit shift register, drives `tx`=0, and goes to START.
- START, DATA, PARITY and STOP each last exactly `CLKS_PER_BIT` cycles, timed by the baud counter. The baud counter is `$clog2(CLKS_PER_BIT)` bits wide and counts 0..CLKS_PER_BIT-1, then wraps.
- DATA: `tx` = shift[0]. The register shifts right at each bit boundary. The 3-bit bit counter runs 0..7; after bit 7 the block moves to PARITY or STOP.
- STOP: `tx`=1. On the last cycle the block pulses `frame_done` and returns to IDLE.
- Back-to-back frames: if the FIFO is still non-empty and `tx_en`=1, the block fetches again immediately. `tx` stays high for 3 cycles (IDLE, FETCH, WAIT) between the stop bit and the next start bit.
- `tx_en` dropping mid-frame has no effect on the current frame. It only blocks the next fetch.
- `empty` is ignored outside IDLE. The block never issues `rd_en` while `empty`=1.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). The byte already popped is discarded.

## Timing
- Fetch latency: `rd_en` rises on the edge after IDLE sees `empty`=0. `tx` falls 2 edges after `rd_en` rises.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- At most one `rd_en` pulse per frame. Minimum spacing between pulses is frame length + 3 cycles, so the FIFO `empty` flag has always settled before the next IDLE check.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `FIFO_UART_TX_PARITY_EN`:
  - Defined: the PARITY state is inserted between DATA and STOP. `tx` carries the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Undefined: DATA goes directly to STOP, and the parity logic is absent.

## Test plan
- Reset: hold `rst`=1 asynchronously mid-DATA with `CLKS_PER_BIT`=4 -> `tx`=1, `rd_en`=0, `busy`=0 within the same cycle. After release, the block stays in IDLE while `empty`=1.
- Single byte: FIFO holds 0xA5, `CLKS_PER_BIT`=4, no parity -> one `rd_en` pulse. `tx` carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles long. `frame_done` pulses once, then `busy`=0.
- Parity build: bytes 0xA5 then 0x07 -> parity bits 0 and 1 respectively. Each frame is 44 cycles.
- Back-to-back: 3 bytes 0x01, 0x80, 0xFF queued -> exactly 3 `rd_en` pulses. The gap between each stop bit and the next start bit is 3 cycles; data matches in order. `empty`=1 is seen after the third pop.
- Flow control: drop `tx_en` during bit 3 of a frame with 2 bytes queued -> the current frame completes and no further `rd_en` is issued. Raising `tx_en` again starts the second frame.
- Empty guard: keep `empty`=1 with `tx_en`=1 for 100 cycles -> `rd_en`=0 and `tx`=1 throughout.
